// File: rtl/sync_event_arbiter.sv
// Round-robin arbiter that turns rising edges on synchronized event lines into
// one-at-a-time valid/ready offers, with one-deep pending flags per requester
// and a saturating counter of events lost to an already-set flag.
module sync_event_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = 2,
  parameter int unsigned CNTW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    sync_in,
  output logic            ev_valid,
  output logic [IDXW-1:0] ev_id,
  input  logic            ev_ready,
  output logic [N-1:0]    pending,
  output logic [CNTW-1:0] drop_count
);

  // Popcount of up to 16 drops needs 5 extra bits of headroom.
  localparam int unsigned         SUMW     = CNTW + 5;
  localparam logic [SUMW-1:0]     CNT_MAX  = SUMW'({CNTW{1'b1}});
  localparam logic [IDXW-1:0]     LAST_RST = IDXW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              ev_valid_q, ev_valid_d;
  logic [IDXW-1:0]   ev_id_q, ev_id_d;
  logic [IDXW-1:0]   last_grant_q, last_grant_d;
  logic [N-1:0]      pending_q, pending_d;
  logic [CNTW-1:0]   drop_q, drop_d;
  logic [N-1:0]      prev_q, prev_d;

  logic [N-1:0]      rise_c;
  logic [N-1:0]      clr_c;
  logic [N-1:0]      drops_c;
  logic              xfer_c;
  logic [SUMW-1:0]   drop_sum_c;
  logic [IDXW-1:0]   sel_c;
  logic              found_c;
  logic [31:0]       rr_idx_c;

  assign xfer_c = (state_q == OFFER) && ev_ready;

  // Rising-edge detection against the previously sampled level.
  always_comb begin
    prev_d = sync_in;
    rise_c = sync_in & ~prev_q;
  end

  // Pending flags: a new rise wins over a same-cycle clear; drops are rises on a
  // flag that stays set.
  always_comb begin
    clr_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      clr_c[i] = xfer_c && (ev_id_q == IDXW'(i));
    end
    drops_c   = rise_c & pending_q & ~clr_c;
    pending_d = (pending_q & ~clr_c) | rise_c;
  end

  // Saturating accumulation of the per-cycle drop popcount.
  always_comb begin
    drop_sum_c = SUMW'(drop_q);
    for (int i = 0; i < int'(N); i++) begin
      drop_sum_c = drop_sum_c + SUMW'(drops_c[i]);
    end
    if (drop_sum_c > CNT_MAX) begin
      drop_d = {CNTW{1'b1}};
    end else begin
      drop_d = drop_sum_c[CNTW-1:0];
    end
  end

  // Round-robin pick: first pending index after last_grant, wrapping modulo N.
  always_comb begin
    sel_c    = '0;
    found_c  = 1'b0;
    rr_idx_c = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      rr_idx_c = (32'(last_grant_q) + 32'(k)) % 32'(N);
      if (!found_c && pending_q[IDXW'(rr_idx_c)]) begin
        found_c = 1'b1;
        sel_c   = IDXW'(rr_idx_c);
      end
    end
  end

  // Offer FSM: IDLE captures a winner, OFFER holds it until the consumer accepts.
  always_comb begin
    state_d      = state_q;
    ev_valid_d   = ev_valid_q;
    ev_id_d      = ev_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        ev_valid_d = 1'b0;
        if (found_c) begin
          ev_id_d    = sel_c;
          ev_valid_d = 1'b1;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        ev_valid_d = 1'b1;
        if (xfer_c) begin
          ev_valid_d   = 1'b0;
          last_grant_d = ev_id_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        ev_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; prev keeps tracking sync_in through reset so held levels
  // are not seen as events on release.
  always_ff @(posedge clock) begin
    prev_q <= prev_d;
    if (reset) begin
      state_q      <= IDLE;
      ev_valid_q   <= 1'b0;
      ev_id_q      <= '0;
      last_grant_q <= LAST_RST;
      pending_q    <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      ev_valid_q   <= ev_valid_d;
      ev_id_q      <= ev_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_id      = ev_id_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Directed bench for sync_event_arbiter (N=4, CNTW=2 so saturation is reachable).
module tb_sync_event_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned IDXW = 2;
  localparam int unsigned CNTW = 2;

  logic            clock;
  logic            reset;
  logic [N-1:0]    sync_in;
  logic            ev_valid;
  logic [IDXW-1:0] ev_id;
  logic            ev_ready;
  logic [N-1:0]    pending;
  logic [CNTW-1:0] drop_count;

  int total = 0;
  int bad   = 0;

  sync_event_arbiter #(.N(N), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clock      (clock),
    .reset      (reset),
    .sync_in    (sync_in),
    .ev_valid   (ev_valid),
    .ev_id      (ev_id),
    .ev_ready   (ev_ready),
    .pending    (pending),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sync_in = '0;
    reset   = 1'b1;
    step();
    step();
    reset   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] exp_p;
    int           exp_d;

    // Reset values, with sync_in[1] held high through reset release.
    reset    = 1'b1;
    sync_in  = 4'b0010;
    ev_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(ev_valid), 32'(0));
    check("rst_id", 32'(ev_id), 32'(0));
    check("rst_pending", 32'(pending), 32'(0));
    check("rst_drop", 32'(drop_count), 32'(0));
    reset = 1'b0;
    step();
    step();
    step();
    check("held_pending", 32'(pending), 32'(0));
    check("held_valid", 32'(ev_valid), 32'(0));
    sync_in = '0;
    step();

    // Single event on input 2, held for three samples.
    sync_in = 4'b0100;
    step();
    check("single_pend", 32'(pending), 32'(4'b0100));
    check("single_valid0", 32'(ev_valid), 32'(0));
    ev_ready = 1'b1;
    step();
    check("single_valid1", 32'(ev_valid), 32'(1));
    check("single_id", 32'(ev_id), 32'(2));
    step();
    sync_in = '0;
    check("single_xfer_valid", 32'(ev_valid), 32'(0));
    check("single_xfer_pend", 32'(pending), 32'(0));
    check("single_drop", 32'(drop_count), 32'(0));
    step();
    check("single_no_reoffer", 32'(ev_valid), 32'(0));

    // Round-robin over two all-ones bursts.
    do_reset();
    ev_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      sync_in = 4'b1111;
      step();
      sync_in = '0;
      check("rr_burst_pend", 32'(pending), 32'(4'b1111));
      exp_p = 4'b1111;
      for (int j = 0; j < 4; j++) begin
        step();
        check("rr_valid", 32'(ev_valid), 32'(1));
        check("rr_id", 32'(ev_id), 32'(j));
        step();
        exp_p = exp_p << 1;
        check("rr_bubble", 32'(ev_valid), 32'(0));
        check("rr_pend", 32'(pending), 32'(exp_p));
      end
    end

    // Backpressure: offer id 1 stalls 10 cycles while input 0 rises.
    do_reset();
    ev_ready = 1'b0;
    sync_in  = 4'b0010;
    step();
    sync_in  = '0;
    step();
    check("bp_valid", 32'(ev_valid), 32'(1));
    check("bp_id", 32'(ev_id), 32'(1));
    for (int s = 0; s < 10; s++) begin
      sync_in = (s == 3) ? 4'b0001 : 4'b0000;
      step();
      check("bp_hold_valid", 32'(ev_valid), 32'(1));
      check("bp_hold_id", 32'(ev_id), 32'(1));
    end
    sync_in = '0;
    check("bp_pend", 32'(pending), 32'(4'b0011));
    ev_ready = 1'b1;
    step();
    check("bp_xfer_valid", 32'(ev_valid), 32'(0));
    check("bp_xfer_pend", 32'(pending), 32'(4'b0001));
    step();
    check("bp_next_valid", 32'(ev_valid), 32'(1));
    check("bp_next_id", 32'(ev_id), 32'(0));
    step();
    check("bp_done_pend", 32'(pending), 32'(0));

    // Drops on input 3 with the consumer stalled; counter saturates at 3.
    do_reset();
    ev_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      sync_in = 4'b1000;
      step();
      exp_d = (p > 3) ? 3 : p;
      check("drop_pend", 32'(pending), 32'(4'b1000));
      check("drop_cnt", 32'(drop_count), 32'(exp_d));
      sync_in = '0;
      step();
    end
    check("drop_offer_valid", 32'(ev_valid), 32'(1));
    check("drop_offer_id", 32'(ev_id), 32'(3));

    // Rise coincident with the transfer of the same requester is kept, not dropped.
    do_reset();
    ev_ready = 1'b0;
    sync_in  = 4'b1000;
    step();
    sync_in  = '0;
    step();
    check("coin_valid", 32'(ev_valid), 32'(1));
    check("coin_id", 32'(ev_id), 32'(3));
    sync_in  = 4'b1000;
    ev_ready = 1'b1;
    step();
    check("coin_pend", 32'(pending), 32'(4'b1000));
    check("coin_drop", 32'(drop_count), 32'(0));
    check("coin_bubble", 32'(ev_valid), 32'(0));
    sync_in = '0;
    step();
    check("coin_reoffer_valid", 32'(ev_valid), 32'(1));
    check("coin_reoffer_id", 32'(ev_id), 32'(3));
    step();
    check("coin_done_pend", 32'(pending), 32'(0));
    check("coin_done_drop", 32'(drop_count), 32'(0));

    // Reset during OFFER discards the offer, drops, and the round-robin pointer.
    do_reset();
    ev_ready = 1'b1;
    sync_in  = 4'b0010;
    step();
    sync_in  = '0;
    step();
    step();
    check("mid_pre_pend", 32'(pending), 32'(0));
    ev_ready = 1'b0;
    sync_in  = 4'b0100;
    step();
    sync_in  = '0;
    step();
    check("mid_offer_id", 32'(ev_id), 32'(2));
    sync_in  = 4'b0100;
    step();
    check("mid_drop", 32'(drop_count), 32'(1));
    sync_in  = '0;
    step();
    reset = 1'b1;
    step();
    check("mid_rst_valid", 32'(ev_valid), 32'(0));
    check("mid_rst_pend", 32'(pending), 32'(0));
    check("mid_rst_drop", 32'(drop_count), 32'(0));
    reset = 1'b0;
    step();
    sync_in = 4'b0101;
    step();
    sync_in = '0;
    check("mid_new_pend", 32'(pending), 32'(4'b0101));
    step();
    check("mid_first_valid", 32'(ev_valid), 32'(1));
    check("mid_first_id", 32'(ev_id), 32'(0));
    ev_ready = 1'b1;
    step();
    step();
    check("mid_second_id", 32'(ev_id), 32'(2));
    check("mid_second_valid", 32'(ev_valid), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
